// File: rtl/router_reg_pkg.sv
// Shared router constants: datapath widths and the reserved destination address.
package router_reg_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned PLEN_W = 6;

   localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

   function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
      return addr != INVALID_ADDR;
   endfunction

endpackage

// File: rtl/router_reg.sv
// Router datapath register: header capture, FIFO byte output, full-buffer byte and
// running parity check, all driven by one-hot strobes from the router FSM.
module router_reg
   import router_reg_pkg::*;
(
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              rst_int_reg,
   input  logic              detect_add,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              lfd_state,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] header,
   input  logic [DATA_W-1:0] parity,
   input  logic [PLEN_W-1:0] payload_len,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              err,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] hold_header_q, hold_header_d;
   logic [DATA_W-1:0] ffb_q, ffb_d;
   logic [DATA_W-1:0] int_parity_q, int_parity_d;
   logic [DATA_W-1:0] pkt_parity_q, pkt_parity_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              parity_done_q, parity_done_d;
   logic              low_pkt_valid_q, low_pkt_valid_d;
   logic              err_q, err_d;

   logic              ld_write;
   logic              ld_last;

   // Sideband monitor inputs have no functional effect.
   logic              unused_sideband;
   assign unused_sideband = ^{addr, header, parity, payload_len};

   assign ld_write = ld_state & ~fifo_full;
   assign ld_last  = ld_write & ~pkt_valid;

   always_comb begin
      hold_header_d = hold_header_q;
      if (detect_add && pkt_valid && addr_valid(data_in[ADDR_W-1:0])) begin
         hold_header_d = data_in;
      end

      dout_d = dout_q;
      if (lfd_state) begin
         dout_d = hold_header_q;
      end else if (ld_write) begin
         dout_d = data_in;
      end else if (laf_state) begin
         dout_d = ffb_q;
      end

      ffb_d = ffb_q;
      if (ld_state && fifo_full) begin
         ffb_d = data_in;
      end

      low_pkt_valid_d = low_pkt_valid_q;
      if (rst_int_reg) begin
         low_pkt_valid_d = 1'b0;
      end else if (ld_state && !pkt_valid) begin
         low_pkt_valid_d = 1'b1;
      end

      parity_done_d = parity_done_q;
      if (detect_add) begin
         parity_done_d = 1'b0;
      end else if (ld_last || (laf_state && low_pkt_valid_q && !parity_done_q)) begin
         parity_done_d = 1'b1;
      end

      // Bytes parked in ffb were already folded in when they were first presented.
      int_parity_d = int_parity_q;
      if (detect_add) begin
         int_parity_d = '0;
      end else if (lfd_state) begin
         int_parity_d = int_parity_q ^ hold_header_q;
      end else if (ld_state && pkt_valid && !full_state) begin
         int_parity_d = int_parity_q ^ data_in;
      end

      pkt_parity_d = pkt_parity_q;
      if (detect_add) begin
         pkt_parity_d = '0;
      end else if (ld_last) begin
         pkt_parity_d = data_in;
      end else if (laf_state && !pkt_valid) begin
         pkt_parity_d = ffb_q;
      end

      err_d = err_q;
      if (detect_add) begin
         err_d = 1'b0;
      end else if (parity_done_q) begin
         err_d = (int_parity_q != pkt_parity_q);
      end
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         hold_header_q   <= '0;
         ffb_q           <= '0;
         int_parity_q    <= '0;
         pkt_parity_q    <= '0;
         dout_q          <= '0;
         parity_done_q   <= 1'b0;
         low_pkt_valid_q <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         hold_header_q   <= hold_header_d;
         ffb_q           <= ffb_d;
         int_parity_q    <= int_parity_d;
         pkt_parity_q    <= pkt_parity_d;
         dout_q          <= dout_d;
         parity_done_q   <= parity_done_d;
         low_pkt_valid_q <= low_pkt_valid_d;
         err_q           <= err_d;
      end
   end

   assign dout          = dout_q;
   assign parity_done   = parity_done_q;
   assign low_pkt_valid = low_pkt_valid_q;
   assign err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: expectations queued per step, checked after each edge.
module tb_router_reg;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic       fifo_full;
   logic       rst_int_reg;
   logic       detect_add;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       lfd_state;
   logic [1:0] addr;
   logic [7:0] header;
   logic [7:0] parity;
   logic [5:0] payload_len;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       err;
   logic [7:0] dout;

   router_reg dut (
      .clock        (clock),
      .resetn       (resetn),
      .pkt_valid    (pkt_valid),
      .data_in      (data_in),
      .fifo_full    (fifo_full),
      .rst_int_reg  (rst_int_reg),
      .detect_add   (detect_add),
      .ld_state     (ld_state),
      .laf_state    (laf_state),
      .full_state   (full_state),
      .lfd_state    (lfd_state),
      .addr         (addr),
      .header       (header),
      .parity       (parity),
      .payload_len  (payload_len),
      .parity_done  (parity_done),
      .low_pkt_valid(low_pkt_valid),
      .err          (err),
      .dout         (dout)
   );

   always #5 clock = ~clock;

   // Strobe encoding: {detect_add, lfd_state, ld_state, laf_state, rst_int_reg}
   localparam logic [4:0] SIdle = 5'b00000;
   localparam logic [4:0] SDet  = 5'b10000;
   localparam logic [4:0] SLfd  = 5'b01000;
   localparam logic [4:0] SLd   = 5'b00100;
   localparam logic [4:0] SLaf  = 5'b00010;
   localparam logic [4:0] SRint = 5'b00001;

   localparam logic [3:0] EnD = 4'b0001;
   localparam logic [3:0] EnP = 4'b0010;
   localparam logic [3:0] EnL = 4'b0100;
   localparam logic [3:0] EnE = 4'b1000;
   localparam logic [3:0] EnA = 4'b1111;

   typedef struct packed {
      logic [3:0] en;
      logic [7:0] d;
      logic       pd;
      logic       lpv;
      logic       er;
   } exp_t;

   exp_t  sb[$];
   string tags[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push(input string tag, input logic [3:0] en, input logic [7:0] d,
                       input logic pd, input logic lpv, input logic er);
      exp_t e;
      e.en  = en;
      e.d   = d;
      e.pd  = pd;
      e.lpv = lpv;
      e.er  = er;
      sb.push_back(e);
      tags.push_back(tag);
   endtask

   task automatic drain();
      exp_t  e;
      string t;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         t = tags.pop_front();
         if (e.en[0]) chk({t, ".dout"}, dout, e.d);
         if (e.en[1]) chk({t, ".parity_done"}, {7'd0, parity_done}, {7'd0, e.pd});
         if (e.en[2]) chk({t, ".low_pkt_valid"}, {7'd0, low_pkt_valid}, {7'd0, e.lpv});
         if (e.en[3]) chk({t, ".err"}, {7'd0, err}, {7'd0, e.er});
      end
   endtask

   task automatic cyc(input logic [4:0] st, input logic pv, input logic [7:0] din,
                      input logic ff);
      {detect_add, lfd_state, ld_state, laf_state, rst_int_reg} = st;
      pkt_valid = pv;
      data_in   = din;
      fifo_full = ff;
      @(posedge clock);
      #1;
      drain();
   endtask

   task automatic rst_cycle();
      resetn = 1'b1;
      {detect_add, lfd_state, ld_state, laf_state, rst_int_reg} = 5'($urandom);
      pkt_valid  = 1'($urandom);
      data_in    = 8'($urandom);
      fifo_full  = 1'($urandom);
      full_state = 1'($urandom);
      @(posedge clock);
      #1;
      drain();
      resetn     = 1'b0;
      full_state = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] pay[14];
   logic [7:0] par;
   logic [7:0] par2;
   logic [7:0] par3;

   initial begin
      resetn      = 1'b1;
      pkt_valid   = 1'b0;
      data_in     = 8'h00;
      fifo_full   = 1'b0;
      full_state  = 1'b0;
      {detect_add, lfd_state, ld_state, laf_state, rst_int_reg} = SIdle;
      addr        = 2'b01;
      header      = 8'h39;
      parity      = 8'h00;
      payload_len = 6'd14;

      // Reset with random stimulus, then an idle cycle
      push("reset", EnA, 8'h00, 1'b0, 1'b0, 1'b0);
      rst_cycle();
      push("idle", EnA, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SIdle, 1'b0, 8'h00, 1'b0);

      // Good packet: header 0x39, 14 payload bytes, correct parity
      par = 8'h39;
      for (int i = 0; i < 14; i++) begin
         pay[i] = 8'($urandom_range(0, 255));
         par    = par ^ pay[i];
      end
      push("good.det", EnA, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SDet, 1'b1, 8'h39, 1'b0);
      push("good.lfd", EnD | EnP, 8'h39, 1'b0, 1'b0, 1'b0);
      cyc(SLfd, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 14; i++) begin
         push("good.ld", EnD | EnP | EnE, pay[i], 1'b0, 1'b0, 1'b0);
         cyc(SLd, 1'b1, pay[i], 1'b0);
      end
      push("good.par", EnA, par, 1'b1, 1'b1, 1'b0);
      cyc(SLd, 1'b0, par, 1'b0);
      push("good.err", EnP | EnE, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(SIdle, 1'b0, 8'h00, 1'b0);
      push("good.rint", EnP | EnL, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(SRint, 1'b0, 8'h00, 1'b0);

      // Same packet with a corrupted parity byte
      push("bad.det", EnP | EnE, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SDet, 1'b1, 8'h39, 1'b0);
      push("bad.lfd", EnD, 8'h39, 1'b0, 1'b0, 1'b0);
      cyc(SLfd, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 14; i++) cyc(SLd, 1'b1, pay[i], 1'b0);
      push("bad.par", EnD | EnP | EnE, par ^ 8'h01, 1'b1, 1'b0, 1'b0);
      cyc(SLd, 1'b0, par ^ 8'h01, 1'b0);
      push("bad.err", EnP | EnE, 8'h00, 1'b1, 1'b0, 1'b1);
      cyc(SIdle, 1'b0, 8'h00, 1'b0);
      push("bad.errhold", EnE, 8'h00, 1'b0, 1'b0, 1'b1);
      cyc(SRint, 1'b0, 8'h00, 1'b0);

      // FIFO full mid-packet: 0xA5 parked in ffb, replayed in the laf cycle
      par2 = 8'h39 ^ 8'h17 ^ 8'hA5;
      push("full.det", EnP | EnE, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SDet, 1'b1, 8'h39, 1'b0);
      push("full.lfd", EnD, 8'h39, 1'b0, 1'b0, 1'b0);
      cyc(SLfd, 1'b1, 8'h00, 1'b0);
      push("full.ld0", EnD, 8'h17, 1'b0, 1'b0, 1'b0);
      cyc(SLd, 1'b1, 8'h17, 1'b0);
      push("full.hold", EnD | EnP, 8'h17, 1'b0, 1'b0, 1'b0);
      cyc(SLd, 1'b1, 8'hA5, 1'b1);
      push("full.laf", EnD | EnP | EnL, 8'hA5, 1'b0, 1'b0, 1'b0);
      cyc(SLaf, 1'b1, 8'h00, 1'b0);
      push("full.par", EnA, par2, 1'b1, 1'b1, 1'b0);
      cyc(SLd, 1'b0, par2, 1'b0);
      push("full.err", EnE, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SIdle, 1'b0, 8'h00, 1'b0);
      push("full.rint", EnL, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SRint, 1'b0, 8'h00, 1'b0);

      // Parity byte arrives while FIFO full; captured from ffb in the laf cycle
      par3 = 8'h39 ^ 8'h17;
      cyc(SDet, 1'b1, 8'h39, 1'b0);
      cyc(SLfd, 1'b1, 8'h00, 1'b0);
      cyc(SLd, 1'b1, 8'h17, 1'b0);
      push("lafpar.full", EnA, 8'h17, 1'b0, 1'b1, 1'b0);
      cyc(SLd, 1'b0, par3, 1'b1);
      push("lafpar.laf", EnD | EnP | EnL, par3, 1'b1, 1'b1, 1'b0);
      cyc(SLaf, 1'b0, 8'h00, 1'b0);
      push("lafpar.err", EnP | EnE, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(SIdle, 1'b0, 8'h00, 1'b0);

      // low_pkt_valid: clear beats set, then set, then clear
      push("lpv.clearwins", EnL, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SLd | SRint, 1'b0, 8'h00, 1'b1);
      push("lpv.set", EnL, 8'h00, 1'b0, 1'b1, 1'b0);
      cyc(SLd, 1'b0, 8'h00, 1'b1);
      push("lpv.clear", EnL, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SRint, 1'b0, 8'h00, 1'b0);

      // Reset mid-packet abandons it
      cyc(SDet, 1'b1, 8'h39, 1'b0);
      cyc(SLfd, 1'b1, 8'h00, 1'b0);
      push("mid.ld", EnD, 8'h55, 1'b0, 1'b0, 1'b0);
      cyc(SLd, 1'b1, 8'h55, 1'b0);
      push("mid.reset", EnA, 8'h00, 1'b0, 1'b0, 1'b0);
      rst_cycle();

      // Invalid address 0x3B must not replace the (reset) header
      push("inv.det", EnD | EnP, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SDet, 1'b1, 8'h3B, 1'b0);
      push("inv.lfd", EnD, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SLfd, 1'b1, 8'h00, 1'b0);

      // Clean packet after the abandoned one
      cyc(SDet, 1'b1, 8'h39, 1'b0);
      push("clean.lfd", EnD, 8'h39, 1'b0, 1'b0, 1'b0);
      cyc(SLfd, 1'b1, 8'h00, 1'b0);
      push("clean.ld", EnD, 8'h5A, 1'b0, 1'b0, 1'b0);
      cyc(SLd, 1'b1, 8'h5A, 1'b0);
      push("clean.par", EnD | EnP, 8'h39 ^ 8'h5A, 1'b1, 1'b0, 1'b0);
      cyc(SLd, 1'b0, 8'h39 ^ 8'h5A, 1'b0);
      push("clean.err", EnE, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(SIdle, 1'b0, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: synchronous reset, active-high (asserted = 1), sampled on the clock rising edge.
REQ-003 SHALL have port pkt_valid, input, 1 bit: source packet valid; deasserts on the parity byte.
REQ-004 SHALL have port data_in, input, 8 bits: packet byte (header, payload or parity).
REQ-005 SHALL have port fifo_full, input, 1 bit: the selected destination FIFO is full.
REQ-006 SHALL have ports rst_int_reg, detect_add, ld_state, laf_state, full_state and lfd_state, all inputs, 1 bit each: one-hot state strobes from the router FSM.
REQ-007 SHALL have ports addr (input, 2 bits), header (input, 8 bits), parity (input, 8 bits) and payload_len (input, 6 bits): sideband monitor inputs with no functional effect.
REQ-008 SHALL have port parity_done, output, 1 bit: the packet parity byte has been captured.
REQ-009 SHALL have port low_pkt_valid, output, 1 bit: pkt_valid dropped while in the load state.
REQ-010 SHALL have port err, output, 1 bit: parity mismatch flag.
REQ-011 SHALL have port dout, output, 8 bits: byte written to the FIFO.

Function
REQ-012 SHALL hold four 8-bit internal registers: hold_header, ffb (full-buffer byte), int_parity and pkt_parity.
REQ-013 SHALL load hold_header with data_in when detect_add=1, pkt_valid=1 and data_in[1:0]!=2'b11.
REQ-014 SHALL update dout with the following priority: lfd_state -> hold_header; ld_state & !fifo_full -> data_in; laf_state -> ffb; otherwise hold.
REQ-015 SHALL load ffb with data_in when ld_state=1 and fifo_full=1; otherwise ffb holds.
REQ-016 SHALL set low_pkt_valid when ld_state=1 and pkt_valid=0, and SHALL clear it when rst_int_reg=1 (clear wins); otherwise it holds.
REQ-017 SHALL set parity_done when (ld_state & !fifo_full & !pkt_valid) or (laf_state & low_pkt_valid & !parity_done); SHALL clear it when detect_add=1 (clear wins); otherwise it holds.
REQ-018 SHALL clear int_parity on detect_add, XOR hold_header into it on lfd_state, and XOR data_in into it on ld_state & pkt_valid & !full_state; otherwise it holds.
REQ-019 SHALL load pkt_parity with data_in on ld_state & !fifo_full & !pkt_valid, or with ffb on laf_state & !pkt_valid; SHALL clear it on detect_add.
REQ-020 SHALL, in the cycle after parity_done is 1, set err to (int_parity != pkt_parity); SHALL clear err on detect_add; otherwise err holds.
REQ-021 SHALL NOT load hold_header when the address is invalid (2'b11); dout and parity state are then unaffected.
REQ-022 SHALL have all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, with resetn=1 at a rising edge, clear dout, hold_header, ffb, int_parity, pkt_parity, parity_done, low_pkt_valid and err to 0, overriding all other conditions.
REQ-024 SHALL, when reset occurs mid-packet, abandon the packet; the next detect_add starts cleanly.

Structure
REQ-025 SHALL take from the shared router package: DATA_W=8, ADDR_W=2, INVALID_ADDR=2'b11 and PLEN_W=6.
REQ-026 SHALL be implemented as a single flat module with no sub-module; the parity logic is inline.

Verification
REQ-027 Reset: assert resetn for 1 cycle with random inputs -> dout=0x00, parity_done=0, low_pkt_valid=0, err=0.
REQ-028 Good packet: header 0x39 (len 14, addr 01), 14 random bytes, correct XOR parity byte, with the FSM sequence detect_add/lfd/ld -> dout streams header then payload; parity_done=1 after the parity byte; err=0 one cycle later.
REQ-029 Bad parity: same packet with the parity byte XORed with 0x01 -> err=1 one cycle after parity_done.
REQ-030 FIFO full: ld_state=1, fifo_full=1, data_in=0xA5, then laf_state=1 -> ffb=0xA5 and dout=0xA5 after the laf cycle.
REQ-031 low_pkt_valid: ld_state=1, pkt_valid=0 -> low_pkt_valid=1; then rst_int_reg=1 -> low_pkt_valid=0.
REQ-032 Invalid address: detect_add=1, pkt_valid=1, data_in=0x3B -> hold_header unchanged; a following lfd_state outputs the previous header (0x00 after reset).
